// File: rtl/dac_spi_sequencer.sv
// Dual-channel DAC update sequencer: on a sample tick, sends an A frame and a B frame over SPI (mode 0), then pulses LDAC.
// Optional macro DAC_SHDN_EN: disabled channels are sent as shutdown frames instead of being skipped.
module dac_spi_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2,
  parameter int LDAC_W  = 2,
  parameter int GAIN_1X = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_sampling,
  input  logic        enableA,
  input  logic        enableB,
  input  logic [11:0] dacA_word,
  input  logic [11:0] dacB_word,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        ldac_n,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_FRAME, S_GAP, S_LDAC, S_DONE} state_t;

  localparam logic L_GAIN = GAIN_1X[0];

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_bit;
  logic [14:0] r_shift;
  logic [15:0] r_frame_b;
  logic        r_pend_b;
  logic        r_sclk, r_mosi, r_cs_n, r_ldac_n, r_busy, r_done, r_overrun;

  logic        w_start;
  logic        w_pend;
  logic [15:0] w_first;
  logic [15:0] w_second;

  // A disabled channel's frame carries SHDN_n=0 and a zero code.
  function automatic logic [15:0] make_frame(input logic is_b, input logic en,
                                             input logic [11:0] code);
    return {is_b, 1'b0, L_GAIN, en, (en ? code : 12'h000)};
  endfunction

`ifdef DAC_SHDN_EN
  assign w_start  = clk_sampling;
  assign w_pend   = 1'b1;
  assign w_first  = make_frame(1'b0, enableA, dacA_word);
  assign w_second = make_frame(1'b1, enableB, dacB_word);
`else
  assign w_start  = clk_sampling & (enableA | enableB);
  assign w_pend   = enableA & enableB;
  assign w_first  = enableA ? make_frame(1'b0, 1'b1, dacA_word)
                            : make_frame(1'b1, 1'b1, dacB_word);
  assign w_second = make_frame(1'b1, 1'b1, dacB_word);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_frame_b <= '0;
      r_pend_b  <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_ldac_n  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Any tick while busy (DONE cycle included) is dropped and flagged.
      if (clk_sampling && r_busy) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_FRAME;
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= w_first[15];
            r_shift   <= w_first[14:0];
            r_frame_b <= w_second;
            r_pend_b  <= w_pend;
            r_cnt     <= '0;
            r_bit     <= '0;
          end
        end
        S_FRAME: begin
          if (r_cnt == 16'(CLK_DIV - 1)) begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              if (r_bit == 4'd15) begin
                r_cs_n  <= 1'b1;
                r_mosi  <= 1'b0;
                r_state <= S_GAP;
              end else begin
                r_bit   <= r_bit + 4'd1;
                r_mosi  <= r_shift[14];
                r_shift <= {r_shift[13:0], 1'b0};
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 16'(CS_GAP - 1)) begin
            r_cnt <= '0;
            if (r_pend_b) begin
              r_state  <= S_FRAME;
              r_pend_b <= 1'b0;
              r_cs_n   <= 1'b0;
              r_mosi   <= r_frame_b[15];
              r_shift  <= r_frame_b[14:0];
              r_bit    <= '0;
            end else begin
              r_state  <= S_LDAC;
              r_ldac_n <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_LDAC: begin
          if (r_cnt == 16'(LDAC_W - 1)) begin
            r_cnt    <= '0;
            r_ldac_n <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi_sclk  = r_sclk;
  assign spi_mosi  = r_mosi;
  assign spi_cs_n  = r_cs_n;
  assign ldac_n    = r_ldac_n;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule
